// File: rtl/comm_pkg.sv
// Shared types and constants for the comm timing controller and its strobe generator.
// Holds the FSM state encoding, the fixed strobe dividers and the phase-match decode values.
package comm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CLEAR,
    MEASURE,
    DONE
  } state_t;

  localparam int INT_DIV = 2;
  localparam int SAM_DIV = 4;
  localparam int SYM_DIV = 16;
  localparam int PHASE_W = $clog2(SYM_DIV);

  // Each divider is a power of two, so a strobe fires when its low phase bits are all ones.
  localparam logic [PHASE_W-1:0] INT_MATCH = PHASE_W'(INT_DIV - 1);
  localparam logic [PHASE_W-1:0] SAM_MATCH = PHASE_W'(SAM_DIV - 1);
  localparam logic [PHASE_W-1:0] SYM_MATCH = PHASE_W'(SYM_DIV - 1);

  function automatic logic strobe_hit(input logic [PHASE_W-1:0] phase,
                                      input logic [PHASE_W-1:0] match);
    return (phase & match) == match;
  endfunction

endpackage

// File: rtl/comm_timing_ctrl_if.sv
// Control/status bundle between the timing controller and its user.
// The master side issues run requests; the slave side (the controller) returns strobes and status.
interface comm_timing_ctrl_if
  import comm_pkg::*;
#(
  parameter int SYM_CNT_W = 20
);

  logic                 start;
  logic                 abort;
  logic [SYM_CNT_W-1:0] meas_len;
  logic                 clk_int;
  logic                 sam_clk;
  logic                 sym_clk;
  logic [PHASE_W-1:0]   phase;
  logic                 clear_accum;
  logic                 accum_en;
  logic                 busy;
  logic                 done;
  logic [SYM_CNT_W-1:0] sym_cnt;

  modport master (
    output start, abort, meas_len,
    input  clk_int, sam_clk, sym_clk, phase, clear_accum, accum_en, busy, done, sym_cnt
  );

  modport slave (
    input  start, abort, meas_len,
    output clk_int, sam_clk, sym_clk, phase, clear_accum, accum_en, busy, done, sym_cnt
  );

endinterface

// File: rtl/comm_strobe_gen.sv
// Free-running sub-symbol phase counter with clk_int/sam_clk/sym_clk enable decode.
// Strobes are combinational on the registered phase, one clk wide; no backpressure, only reset stops it.
module comm_strobe_gen
  import comm_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  output logic [PHASE_W-1:0] phase,
  output logic               clk_int,
  output logic               sam_clk,
  output logic               sym_clk
);

  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_d;

  always_comb begin
    phase_d = phase_q + PHASE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase   = phase_q;
  assign clk_int = strobe_hit(phase_q, INT_MATCH);
  assign sam_clk = strobe_hit(phase_q, SAM_MATCH);
  assign sym_clk = strobe_hit(phase_q, SYM_MATCH);

endmodule

// File: rtl/comm_timing_ctrl.sv
// Measurement-run sequencer (settle, clear, measure, done) driven by symbol ticks from comm_strobe_gen.
// Outputs are registered one edge after the deciding input; start is ignored while busy, abort wins always.
module comm_timing_ctrl
  import comm_pkg::*;
#(
  parameter int SYM_CNT_W   = 20,
  parameter int SETTLE_SYMS = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  comm_timing_ctrl_if.slave        bus
);

  localparam int SETTLE_W = $clog2(SETTLE_SYMS + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_SYMS - 1);

  logic sym_tick;

  comm_strobe_gen u_strobe (
    .clk     (clk),
    .reset   (reset),
    .phase   (bus.phase),
    .clk_int (bus.clk_int),
    .sam_clk (bus.sam_clk),
    .sym_clk (sym_tick)
  );

  assign bus.sym_clk = sym_tick;

  state_t               state_q,      state_d;
  logic [SYM_CNT_W-1:0] len_q,        len_d;
  logic [SETTLE_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [SYM_CNT_W-1:0] sym_cnt_q,    sym_cnt_d;
  logic                 busy_q,       busy_d;
  logic                 done_q,       done_d;
  logic                 clear_accum_q, clear_accum_d;
  logic                 accum_en_q,   accum_en_d;
  logic [SYM_CNT_W-1:0] sym_cnt_inc;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    settle_cnt_d = settle_cnt_q;
    sym_cnt_d    = sym_cnt_q;
    sym_cnt_inc  = sym_cnt_q + SYM_CNT_W'(1);

    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_d      = SETTLE;
            // A zero-length request still measures one symbol so done always means data.
            len_d        = (bus.meas_len == '0) ? SYM_CNT_W'(1) : bus.meas_len;
            settle_cnt_d = '0;
            sym_cnt_d    = '0;
          end
        end
        SETTLE: begin
          if (sym_tick) begin
            if (settle_cnt_q == SETTLE_LAST) begin
              state_d = CLEAR;
            end else begin
              settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
            end
          end
        end
        CLEAR: begin
          if (sym_tick) begin
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          if (sym_tick) begin
            sym_cnt_d = sym_cnt_inc;
            if (sym_cnt_inc == len_q) begin
              state_d = DONE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Status is decoded from the next state so it lines up with the state register.
    busy_d        = (state_d == SETTLE) || (state_d == CLEAR) || (state_d == MEASURE);
    done_d        = (state_d == DONE);
    clear_accum_d = (state_d == CLEAR);
    accum_en_d    = (state_d == MEASURE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      len_q         <= SYM_CNT_W'(1);
      settle_cnt_q  <= '0;
      sym_cnt_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      clear_accum_q <= 1'b0;
      accum_en_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      settle_cnt_q  <= settle_cnt_d;
      sym_cnt_q     <= sym_cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      clear_accum_q <= clear_accum_d;
      accum_en_q    <= accum_en_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.clear_accum = clear_accum_q;
  assign bus.accum_en    = accum_en_q;
  assign bus.sym_cnt     = sym_cnt_q;

endmodule

// File: tb/tb_comm_timing_ctrl.sv
// Bench for comm_timing_ctrl: directed runs push expected window/status events into a queue,
// and a negedge monitor turns DUT edges into events and compares them in order.
module tb_comm_timing_ctrl;

  localparam int SYM_CNT_W = 20;
  localparam int SETTLE    = 4;

  typedef enum int {EV_SETTLE, EV_CLEAR, EV_ACCUM, EV_DONE, EV_ABORT} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    int unsigned val;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  ev_t         exp_q[$];

  comm_timing_ctrl_if #(.SYM_CNT_W(SYM_CNT_W)) bus ();

  comm_timing_ctrl #(.SYM_CNT_W(SYM_CNT_W), .SETTLE_SYMS(SETTLE)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input ev_kind_t kind, input int unsigned val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // Start in cycle c -> busy in c+1; the clear window opens after SETTLE ticks at phase 15.
  function automatic int unsigned exp_settle(input int unsigned c);
    return 16 * SETTLE - ((c + 1) % 16);
  endfunction

  task automatic push_run(input int unsigned settle, input int unsigned len);
    push_ev(EV_SETTLE, settle);
    push_ev(EV_CLEAR, 16);
    push_ev(EV_ACCUM, 16 * len);
    push_ev(EV_DONE, len);
  endtask

  task automatic check_ev(input ev_kind_t kind, input int unsigned val, input string name);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: unexpected event value %0d, nothing expected (cycle %0d)", name, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val) begin
        miscompares++;
        $display("FAIL %s: got event %s=%0d, expected %s=%0d (cycle %0d)",
                 name, kind.name(), val, e.kind.name(), e.val, cyc);
      end
    end
  endtask

  // Monitor: converts output edges into events.
  logic        p_busy = 0, p_clr = 0, p_acc = 0, p_done = 0;
  int unsigned clr_w = 0, acc_w = 0, busy_rise = 0;

  always @(negedge clk) begin
    if (rst) begin
      p_busy = 0; p_clr = 0; p_acc = 0; p_done = 0;
      clr_w  = 0; acc_w = 0;
    end else begin
      if (bus.busy && !p_busy) busy_rise = cyc;
      if (bus.clear_accum && !p_clr) check_ev(EV_SETTLE, cyc - busy_rise, "settle_len");
      if (bus.clear_accum) clr_w++;
      else if (p_clr) begin check_ev(EV_CLEAR, clr_w, "clear_width"); clr_w = 0; end
      if (bus.accum_en) acc_w++;
      else if (p_acc) begin check_ev(EV_ACCUM, acc_w, "accum_width"); acc_w = 0; end
      if (bus.done && !p_done)
        check_ev(EV_DONE, (32'(bus.busy) << 31) | 32'(bus.sym_cnt), "done_status");
      if (!bus.busy && p_busy && !bus.done)
        check_ev(EV_ABORT, (32'(bus.accum_en) << 22) | (32'(bus.clear_accum) << 21) |
                           (32'(bus.done) << 20) | 32'(bus.sym_cnt), "abort_status");
      p_busy = bus.busy; p_clr = bus.clear_accum; p_acc = bus.accum_en; p_done = bus.done;
    end
  end

  function automatic logic sig_sel(input int which);
    case (which)
      0:       return bus.done;
      1:       return bus.accum_en;
      2:       return bus.clear_accum;
      default: return bus.busy;
    endcase
  endfunction

  task automatic wait_sig(input int which, input logic val, input int max_cyc, input string name);
    int n = 0;
    while (sig_sel(which) !== val && n < max_cyc) begin
      step();
      n++;
    end
    if (sig_sel(which) !== val) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: timeout after %0d cycles, signal still %0b", name, n, sig_sel(which));
    end
  endtask

  function automatic int unsigned all_outputs();
    return (32'(bus.phase) << 27) | (32'(bus.clk_int) << 26) | (32'(bus.sam_clk) << 25) |
           (32'(bus.sym_clk) << 24) | (32'(bus.clear_accum) << 23) | (32'(bus.accum_en) << 22) |
           (32'(bus.busy) << 21) | (32'(bus.done) << 20) | 32'(bus.sym_cnt);
  endfunction

  initial begin
    int unsigned exp_strb;
    int ticks;
    int n;

    bus.start = 0; bus.abort = 0; bus.meas_len = '0;
    rst = 1;
    repeat (3) step();
    chk("reset_outputs", all_outputs(), 0);

    // 1: strobe pattern over 64 cycles after release
    rst = 0;
    for (int k = 0; k < 64; k++) begin
      exp_strb = ((k % 16) << 3) | (32'(k % 16 == 15) << 2) | (32'(k % 4 == 3) << 1) | 32'(k % 2 == 1);
      chk("strobes", (32'(bus.phase) << 3) | (32'(bus.sym_clk) << 2) |
                     (32'(bus.sam_clk) << 1) | 32'(bus.clk_int), exp_strb);
      step();
    end

    // 2: meas_len=10, start pulse at cycle 20 after a fresh reset
    rst = 1;
    step();
    rst = 0;
    repeat (20) step();
    bus.meas_len = 10;
    bus.start = 1;
    push_run(exp_settle(cyc), 10);
    step();
    bus.start = 0;
    chk("busy_after_start", bus.busy, 1);
    wait_sig(0, 1, 3000, "wait_done_t2");
    repeat (20) step();
    chk("done_sticky", (32'(bus.done) << 21) | (32'(bus.busy) << 20) | 32'(bus.sym_cnt),
        (1 << 21) | 10);

    // 3: zero length counts as one symbol; start from DONE clears done
    bus.meas_len = 0;
    bus.start = 1;
    push_run(exp_settle(cyc), 1);
    step();
    bus.start = 0;
    chk("done_clears_on_start", (32'(bus.done) << 1) | 32'(bus.busy), 1);
    wait_sig(0, 1, 3000, "wait_done_t3");

    // 4: abort during MEASURE after 3 ticks
    bus.meas_len = 10;
    bus.start = 1;
    push_ev(EV_SETTLE, exp_settle(cyc));
    push_ev(EV_CLEAR, 16);
    push_ev(EV_ACCUM, 49);
    push_ev(EV_ABORT, 3);
    step();
    bus.start = 0;
    bus.meas_len = 0;
    wait_sig(1, 1, 3000, "wait_accum_t4");
    ticks = 0;
    n = 0;
    while (ticks < 3 && n < 200) begin
      if (bus.sym_clk) ticks++;
      step();
      n++;
    end
    bus.abort = 1;
    step();
    bus.abort = 0;
    chk("after_abort", (32'(bus.busy) << 22) | (32'(bus.accum_en) << 21) |
                       (32'(bus.done) << 20) | 32'(bus.sym_cnt), 3);
    repeat (7) step();
    chk("phase_continues", bus.phase, cyc % 16);
    bus.start = 1;
    bus.abort = 1;
    step();
    bus.start = 0;
    bus.abort = 0;
    chk("abort_beats_start", bus.busy, 0);

    // 5: start held through a run; meas_len change mid-run applies only to the next run
    bus.meas_len = 2;
    bus.start = 1;
    push_run(exp_settle(cyc), 2);
    push_run(63, 5);
    step();
    bus.meas_len = 5;
    wait_sig(0, 1, 3000, "wait_done_t5a");
    step();
    chk("done_one_cycle", (32'(bus.done) << 1) | 32'(bus.busy), 1);
    bus.start = 0;
    wait_sig(0, 1, 3000, "wait_done_t5b");

    // 6: reset during CLEAR
    bus.meas_len = 3;
    bus.start = 1;
    push_ev(EV_SETTLE, exp_settle(cyc));
    step();
    bus.start = 0;
    wait_sig(2, 1, 3000, "wait_clear_t6");
    repeat (5) step();
    rst = 1;
    step();
    chk("reset_mid_clear", all_outputs(), 0);
    rst = 0;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.sym_clk && n < 40);
    chk("first_sym_after_reset", n, 15);

    repeat (5) step();
    chk("events_outstanding", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
